// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the bit-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must hold N-1; a one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo set on underflow.
// Purely combinational so it can be exercised on its own over all 8 inputs.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, through
// one full-subtractor cell and a registered borrow, with a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_r;
  state_t        state_s;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  res_r;
  logic [N-1:0]  res_s;
  logic          br_r;
  logic [CW-1:0] cnt_r;
  logic          d_s;
  logic          bo_s;
  logic          last_s;
  logic          busy_s;
  logic          done_s;

  full_subtractor u_fs (
    .x  (a_r[0]),
    .y  (b_r[0]),
    .bi (br_r),
    .d  (d_s),
    .bo (bo_s)
  );

  // New bit enters at the MSB so that after N shifts bit 0 holds the LSB.
  generate
    if (N == 1) begin : g_res_one
      assign res_s = d_s;
    end else begin : g_res_many
      assign res_s = {d_s, res_r[N-1:1]};
    end
  endgenerate

  assign last_s = (cnt_r == LAST);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SHIFT;
        else       state_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_s = DONE;
        else        state_s = SHIFT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, then registered.
  always_comb begin
    busy_s = (state_s == SHIFT);
    done_s = (state_s == DONE);
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

  // Operand/result shift registers, borrow flop, bit counter and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      br_r  <= 1'b0;
      cnt_r <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            br_r  <= bin;
            cnt_r <= '0;
            res_r <= '0;
          end
        end
        SHIFT: begin
          a_r   <= a_r >> 1'b1;
          b_r   <= b_r >> 1'b1;
          br_r  <= bo_s;
          cnt_r <= cnt_r + CW'(1);
          res_r <= res_s;
          if (last_s) begin
            diff <= res_s;
            bout <= bo_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
